// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and constants for the GPIO requester arbiter.
//   gpio_arb_state_t : arbiter FSM state (IDLE -> ISSUE -> RESP -> IDLE)
//   GPIO_DW          : GPIO register width
//   GPIO_ARB_MAX_REQ : largest supported requester count
package gpio_arb_pkg;

  localparam int GPIO_DW          = 32;
  localparam int GPIO_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } gpio_arb_state_t;

endpackage

// File: rtl/gpio_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     in  NREQ : request vector
//   last    in  LW   : index of the previous winner
//   win     out NREQ : one-hot winner (all zero when no request)
//   win_idx out LW   : binary winner index (equals last when no request)
// Priority starts at last+1 and wraps modulo NREQ, so last itself is
// checked last.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [LW-1:0]   win_idx
);

  always_comb begin
    int          idx;
    logic [LW-1:0] pos;
    idx     = 0;
    pos     = '0;
    win_idx = last;
    win     = '0;
    // Walk from the lowest priority (offset NREQ) to the highest (offset 1);
    // the last hit written is the highest-priority requester.
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      pos = LW'(idx);
      if (req[pos]) win_idx = pos;
    end
    if (|req) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/gpio_arbiter.sv
// gpio_arbiter: round-robin sharing of one GPIO register block between
// NREQ requesters. Each transaction is IDLE (sample) -> ISSUE (gnt + one
// strobe) -> RESP (wait for GPIO) -> IDLE with done pulse.
//   clk, reset          : clock, synchronous active-high reset
//   req/wr/wdata        : per-requester request level, op (1=write), data
//   gnt, done           : one-hot grant / completion pulses
//   rdata               : last read result, held until the next read
//   busy                : high in ISSUE and RESP
//   gpio_we/gpio_re     : one-cycle GPIO strobes
//   gpio_data_in/out    : GPIO data port
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = GPIO_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              gpio_we,
  output logic              gpio_re,
  output logic [DW-1:0]     gpio_data_in,
  input  logic [DW-1:0]     gpio_data_out
);

  localparam int LW = $clog2(NREQ);

  gpio_arb_state_t          state;
  logic [LW-1:0]            last;
  logic [LW-1:0]            win_idx;
  logic [NREQ-1:0]          win;
  logic                     wr_l;
  logic [NREQ-1:0][DW-1:0]  wdata_v;

  assign wdata_v = wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  // gpio_data_in doubles as the write-data latch: it is loaded only on a
  // write grant, which also keeps it stable across reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last         <= LW'(NREQ - 1);
      wr_l         <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      gpio_we      <= 1'b0;
      gpio_re      <= 1'b0;
      gpio_data_in <= '0;
    end else begin
      gnt     <= '0;
      done    <= '0;
      gpio_we <= 1'b0;
      gpio_re <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= ISSUE;
            last    <= win_idx;
            wr_l    <= wr[win_idx];
            gnt     <= win;
            gpio_we <= wr[win_idx];
            gpio_re <= ~wr[win_idx];
            busy    <= 1'b1;
            if (wr[win_idx]) gpio_data_in <= wdata_v[win_idx];
          end
        end
        ISSUE: state <= RESP;
        RESP: begin
          // last still holds the current winner here.
          if (!wr_l) rdata <= gpio_data_out;
          done[last] <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: directed scenarios plus a randomized run checked against
// a transaction-timeline model of the arbiter and a register model of GPIO.
module tb_gpio_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int MAXC = 512;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req, wr;
  logic [63:0]     wdata;
  logic [1:0]      gnt, done;
  logic [31:0]     rdata;
  logic            busy, gpio_we, gpio_re;
  logic [31:0]     gpio_data_in, gpio_data_out;
  logic [31:0]     gpio_reg;

  int n_chk  = 0;
  int n_pass = 0;

  // timeline of expected per-cycle events for the random test
  logic [1:0]  ev_gnt  [0:MAXC+3];
  logic [1:0]  ev_done [0:MAXC+3];
  logic        ev_busy [0:MAXC+3];
  logic        ev_we   [0:MAXC+3];
  logic        ev_re   [0:MAXC+3];
  logic        din_chg [0:MAXC+3];
  logic        rd_chg  [0:MAXC+3];
  logic [31:0] din_val [0:MAXC+3];
  logic [31:0] rd_val  [0:MAXC+3];

  gpio_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .wr            (wr),
    .wdata         (wdata),
    .gnt           (gnt),
    .done          (done),
    .rdata         (rdata),
    .busy          (busy),
    .gpio_we       (gpio_we),
    .gpio_re       (gpio_re),
    .gpio_data_in  (gpio_data_in),
    .gpio_data_out (gpio_data_out)
  );

  initial forever #5 clk = ~clk;

  // GPIO register stand-in: resets to 0, writes on the strobe edge.
  always @(posedge clk) begin
    if (reset) gpio_reg <= '0;
    else if (gpio_we) gpio_reg <= gpio_data_in;
  end
  assign gpio_data_out = gpio_reg;

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; wr = 2'b00; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if ({gnt, done, busy, gpio_we, gpio_re, gpio_data_in, rdata} !== 71'd0)
        $display("FAIL reset_outputs cycle %0d: got %h required 0", i,
                 {gnt, done, busy, gpio_we, gpio_re, gpio_data_in, rdata});
      else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 2'b01) $display("FAIL first_grant: got %b required 01", gnt);
    else n_pass++;
    req = 2'b00;
    repeat (2) @(negedge clk);
    n_chk++;
    if (done !== 2'b01) $display("FAIL first_done: got %b required 01", done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int g, d, nwe, nre;
    logic we_g;
    logic [31:0] din_g;
    g = -1; d = -1; nwe = 0; nre = 0; we_g = 1'b0; din_g = '0;
    req = 2'b01; wr = 2'b01; wdata[31:0] = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gpio_we) nwe++;
      if (gpio_re) nre++;
      if (gnt[0] && g < 0) begin g = i; we_g = gpio_we; din_g = gpio_data_in; req = 2'b00; end
      if (done[0] && d < 0) d = i;
    end
    n_chk++;
    if (g !== 0 || we_g !== 1'b1) $display("FAIL wr_grant: got cycle %0d we %b required cycle 0 we 1", g, we_g);
    else n_pass++;
    n_chk++;
    if (din_g !== 32'hA5A5A5A5) $display("FAIL wr_data_in: got %h required a5a5a5a5", din_g);
    else n_pass++;
    n_chk++;
    if (d !== g + 2) $display("FAIL wr_done_latency: got cycle %0d required %0d", d, g + 2);
    else n_pass++;
    n_chk++;
    if (nwe !== 1 || nre !== 0) $display("FAIL wr_strobes: got we %0d re %0d required 1 0", nwe, nre);
    else n_pass++;
  endtask

  task automatic test_readback();
    int g, d, nwe, nre;
    logic [31:0] rd_d;
    g = -1; d = -1; nwe = 0; nre = 0; rd_d = '0;
    req = 2'b10; wr = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gpio_we) nwe++;
      if (gpio_re) nre++;
      if (gnt[1] && g < 0) begin g = i; req = 2'b00; end
      if (done[1] && d < 0) begin d = i; rd_d = rdata; end
    end
    n_chk++;
    if (nre !== 1 || nwe !== 0) $display("FAIL rd_strobes: got re %0d we %0d required 1 0", nre, nwe);
    else n_pass++;
    n_chk++;
    if (g !== 0 || d !== 2) $display("FAIL rd_timing: got gnt %0d done %0d required 0 2", g, d);
    else n_pass++;
    n_chk++;
    if (rd_d !== 32'hA5A5A5A5) $display("FAIL rd_data: got %h required a5a5a5a5", rd_d);
    else n_pass++;
  endtask

  task automatic test_contention();
    int ng;
    int gcyc [4];
    int gwho [4];
    logic [31:0] gdin [4];
    logic [31:0] want;
    ng = 0;
    req = 2'b11; wr = 2'b11; wdata = {32'h0000FFFF, 32'h12345678};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (ng < 4) begin
          gcyc[ng] = i; gwho[ng] = gnt[1] ? 1 : 0; gdin[ng] = gpio_data_in;
        end
        ng++;
      end
      if (i == 11) req = 2'b00;
    end
    n_chk++;
    if (ng !== 4) $display("FAIL cont_count: got %0d grants required 4", ng);
    else n_pass++;
    for (int j = 0; j < 4 && j < ng; j++) begin
      want = (j % 2) ? 32'h0000FFFF : 32'h12345678;
      n_chk++;
      if (gwho[j] !== j % 2 || gcyc[j] !== 3 * j || gdin[j] !== want)
        $display("FAIL cont_grant%0d: got req%0d cycle %0d data %h required req%0d cycle %0d data %h",
                 j, gwho[j], gcyc[j], gdin[j], j % 2, 3 * j, want);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int nd, nst, d;
    logic [31:0] rd_d;
    nd = 0; nst = 0; d = -1; rd_d = 32'hFFFFFFFF;
    req = 2'b01; wr = 2'b01; wdata[31:0] = 32'h12345678;
    @(negedge clk);
    n_chk++;
    if (gnt !== 2'b01 || gpio_we !== 1'b1) $display("FAIL abort_issue: got gnt %b we %b required 01 1", gnt, gpio_we);
    else n_pass++;
    reset = 1'b1; req = 2'b00;
    @(negedge clk);
    n_chk++;
    if ({gpio_we, gpio_re, busy, gnt, done, rdata, gpio_data_in} !== 71'd0)
      $display("FAIL abort_reset_state: got %h required 0", {gpio_we, gpio_re, busy, gnt, done, rdata, gpio_data_in});
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done != 2'b00) nd++;
      if (gpio_we || gpio_re) nst++;
    end
    n_chk++;
    if (nd !== 0 || nst !== 0) $display("FAIL abort_no_done: got done %0d strobes %0d required 0 0", nd, nst);
    else n_pass++;
    req = 2'b01; wr = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt[0]) req = 2'b00;
      if (done[0] && d < 0) begin d = i; rd_d = rdata; end
    end
    n_chk++;
    if (d !== 2 || rd_d !== 32'h0) $display("FAIL abort_readback: got done %0d rdata %h required 2 00000000", d, rd_d);
    else n_pass++;
  endtask

  task automatic test_cancel();
    int ng1;
    ng1 = 0;
    req = 2'b01; wr = 2'b01; wdata[31:0] = 32'hCAFEF00D;
    @(negedge clk);
    req = 2'b10; wr = 2'b00;
    @(negedge clk);
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt[1]) ng1++;
    end
    n_chk++;
    if (ng1 !== 0) $display("FAIL cancel_no_grant: got %0d grants to req1 required 0", ng1);
    else n_pass++;
    req = 2'b11; wr = 2'b00;
    @(negedge clk);
    n_chk++;
    if (gnt !== 2'b10) $display("FAIL cancel_last_kept: got %b required 10", gnt);
    else n_pass++;
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random(input int ncyc);
    logic [1:0]  pend, pop;
    logic [31:0] pdat [2];
    logic [31:0] cur_din, cur_rd, mem;
    logic [70:0] obs, expv;
    int last_m, free, w;
    for (int k = 0; k <= MAXC + 3; k++) begin
      ev_gnt[k] = '0; ev_done[k] = '0; ev_busy[k] = 1'b0; ev_we[k] = 1'b0; ev_re[k] = 1'b0;
      din_chg[k] = 1'b0; rd_chg[k] = 1'b0; din_val[k] = '0; rd_val[k] = '0;
    end
    @(negedge clk);
    reset = 1'b1; req = 2'b00; wr = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    pend = '0; pop = '0; pdat[0] = '0; pdat[1] = '0;
    cur_din = '0; cur_rd = '0; mem = '0; last_m = NREQ - 1; free = 1;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      if (din_chg[k]) cur_din = din_val[k];
      if (rd_chg[k])  cur_rd  = rd_val[k];
      expv = {ev_gnt[k], ev_done[k], ev_busy[k], ev_we[k], ev_re[k], cur_din, cur_rd};
      obs  = {gnt, done, busy, gpio_we, gpio_re, gpio_data_in, rdata};
      n_chk++;
      if (obs !== expv) $display("FAIL random cycle %0d: got %h required %h", k, obs, expv);
      else n_pass++;
      // requesters: release on grant, start new work or cancel at random
      for (int i = 0; i < 2; i++) begin
        if (ev_gnt[k][i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1; pop[i] = 1'($urandom_range(0, 1)); pdat[i] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      req = pend; wr = pop; wdata = {pdat[1], pdat[0]};
      // next edge samples req only if the previous transaction has finished
      if (k + 1 >= free && pend != 2'b00) begin
        w = -1;
        for (int j = 1; j <= NREQ; j++)
          if (w < 0 && pend[(last_m + j) % NREQ]) w = (last_m + j) % NREQ;
        ev_gnt[k+1][w] = 1'b1;
        ev_busy[k+1] = 1'b1; ev_busy[k+2] = 1'b1;
        ev_done[k+3][w] = 1'b1;
        if (pop[w]) begin
          ev_we[k+1] = 1'b1; din_chg[k+1] = 1'b1; din_val[k+1] = pdat[w]; mem = pdat[w];
        end else begin
          ev_re[k+1] = 1'b1; rd_chg[k+3] = 1'b1; rd_val[k+3] = mem;
        end
        last_m = w;
        free = k + 4;
      end
    end
    req = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_abort();
    test_cancel();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
# gpio_arbiter

Round-robin arbiter that shares the single GPIO register block between NREQ independent requesters, such as the core load/store path and a debug/UART bridge. It serialises requests into one-cycle `we`/`re` strobes on the GPIO's `data_in`/`data_out` port and returns completion and read data to the winning requester. The arbiter sits directly in front of the GPIO instance; the GPIO port names and widths are unchanged.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters. Legal range is 2–8.
- `DW`, default 32: data width. Matches the GPIO width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: per-requester request level.
- `wr` in NREQ: per-requester operation; 1 = write, 0 = read. Valid while `req[i]` is high.
- `wdata` in NREQ*DW: per-requester write data, slice `[i*DW +: DW]`. Valid while `req[i]` is high.
- `gnt` out NREQ: one-hot, one-cycle grant pulse.
- `done` out NREQ: one-hot, one-cycle completion pulse.
- `rdata` out DW: read data. Valid in the `done` cycle of a read; held until the next read completes.
- `busy` out 1: high while a transaction is in flight (states ISSUE and RESP).
- `gpio_we` out 1: GPIO write strobe.
- `gpio_re` out 1: GPIO read strobe.
- `gpio_data_in` out DW: data to the GPIO.
- `gpio_data_out` in DW: data from the GPIO.

## Operation
- FSM has three states: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE:** if any `req` bit is sampled high, pick winner `w` round-robin.
  - Latch `wr[w]` and `wdata[w]`.
  - Next state is ISSUE. Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle):
  - `gnt[w]`=1.
  - `gpio_we`=`wr_l` and `gpio_re`=!`wr_l`.
  - `gpio_data_in` = latched `wdata` on a write. On a read it keeps its previous value.
  - Next state is RESP.
- **RESP** (exactly 1 cycle): on its closing edge, perform these actions and then enter IDLE.
  - On a read, capture `rdata` <= `gpio_data_out`.
  - Assert `done[w]`=1 for the following cycle, which is IDLE.
- **Round-robin priority:**
  - `last` pointer, `$clog2(NREQ)` bits. It is updated to `w` on each grant.
  - Search starts at `last`+1, wrapping modulo NREQ.
  - Reset value of `last` is NREQ-1, so requester 0 wins first.
- **Requester rules:**
  - Hold `req`, `wr` and `wdata` stable until `gnt` is seen.
  - If `req` is still high in the `done` cycle, it is a new request.
  - Dropping `req` before the grant sample cancels the request with no side effects.
  - Requests arriving during ISSUE or RESP are not sampled until IDLE.
- **Simultaneous requests:** exactly one grant per transaction; losers wait. No requester waits more than NREQ-1 transactions.
- **`gpio_data_in`:** changes only in ISSUE of a write and is stable otherwise.

## Timing
- **Reset values:** `gnt`, `done`, `rdata`, `busy`, `gpio_we`, `gpio_re` and `gpio_data_in` are all 0; state is IDLE; `last`=NREQ-1.
- **Cycle sequence:**
  - Edge E0 samples `req` in IDLE.
  - Cycle E0–E1 is ISSUE: `gnt`, strobe and `busy` are high.
  - GPIO writes, or presents read data, at E1.
  - Cycle E1–E2 is RESP: `busy` is high and strobes are low.
  - Edge E2 captures `rdata`.
  - Cycle E2–E3 is IDLE with `done[w]`=1.
  - The next request is sampled at E3.
- **Latency and throughput:** latency from the request-sample edge to the `done` pulse is 2 cycles. Peak throughput is one transaction per 3 cycles.
- **Reset mid-transaction:** `reset` high at any edge forces all reset values on that edge. The transaction is aborted: no `done` pulse, and the GPIO sees no further strobe.
- **Strobe width:** `gpio_we` and `gpio_re` are never high together, and never high for more than 1 consecutive cycle.

## Structure
- **Package `gpio_arb_pkg`:**
  - FSM state enum `gpio_arb_state_t` {IDLE, ISSUE, RESP}.
  - Constants `GPIO_DW`=32 and `GPIO_ARB_MAX_REQ`=8.
- **Sub-module `rr_pick`:** combinational round-robin picker, parameter NREQ.
  - Inputs are `req` and `last`.
  - Outputs are one-hot `win` and `win_idx`.
  - Reusable by other shared-peripheral arbiters.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `req`=2'b11. All outputs are 0 and there is no `gnt` during reset. After release, `gnt[0]` is the first grant.
- **Single write:** req0 writes 0xA5A5A5A5.
  - `gnt[0]` and `gpio_we` are high for one cycle, with `gpio_data_in`=0xA5A5A5A5.
  - `done[0]` follows 2 cycles after `gnt[0]`.
  - `gpio_re` is never high.
- **Read-back:** then req1 reads. `gpio_re` pulses once, and `done[1]` arrives with `rdata`=0xA5A5A5A5.
- **Contention:** both requesters hold `req` continuously, writing 0x12345678 (req0) and 0x0000FFFF (req1).
  - Grants alternate 0,1,0,1 every 3 cycles.
  - `gpio_data_in` alternates correspondingly.
- **Abort:** assert `reset` in the ISSUE cycle of a write of 0x12345678.
  - `gpio_we` is 0 the next cycle and no `done` pulse occurs.
  - A following read returns 0x00000000 in `rdata`, matching GPIO reset.
- **Cancel:** req1 pulses for 1 cycle while the arbiter is `busy`. No `gnt[1]` is ever issued and `last` is unchanged.
